// File: rtl/rename_commit_tracker.sv
// In-order tracker of renamed instructions: frees old physical registers on commit
// and replays youngest-first map rollbacks after a flush.
module rename_commit_tracker #(
  parameter int unsigned ARCH_REG_WIDTH = 5,
  parameter int unsigned PHYS_REG_WIDTH = 6,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  input  logic [ARCH_REG_WIDTH-1:0]     alloc_rd_i,
  input  logic [PHYS_REG_WIDTH-1:0]     alloc_prd_i,
  input  logic [PHYS_REG_WIDTH-1:0]     alloc_old_prd_i,
  input  logic                          commit_valid_i,
  output logic                          commit_ready_o,
  input  logic [PHYS_REG_WIDTH-1:0]     commit_prd_i,
  input  logic                          flush_i,
  output logic                          free_valid_o,
  output logic [PHYS_REG_WIDTH-1:0]     free_prd_o,
  output logic                          rb_valid_o,
  output logic [ARCH_REG_WIDTH-1:0]     rb_rd_o,
  output logic [PHYS_REG_WIDTH-1:0]     rb_prd_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef enum logic {IDLE, ROLLBACK} state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] head_q, tail_q, rb_idx;
  logic [CNT_W-1:0] count_q;

  logic [ARCH_REG_WIDTH-1:0] rd_mem     [DEPTH];
  logic [PHYS_REG_WIDTH-1:0] prd_mem    [DEPTH];
  logic [PHYS_REG_WIDTH-1:0] old_prd_mem[DEPTH];

  logic do_alloc, do_commit, do_rb;

  // Handshakes depend only on registered state, never on same-cycle inputs.
  always_comb begin
    alloc_ready_o  = (state_q == IDLE) && (count_q != FULL_C);
    commit_ready_o = (state_q == IDLE) && (count_q != '0);
    do_alloc       = alloc_valid_i  && alloc_ready_o  && !flush_i;
    do_commit      = commit_valid_i && commit_ready_o && !flush_i;
    do_rb          = (state_q == ROLLBACK);
    rb_idx         = tail_q - PTR_W'(1);
  end

  assign count_o = count_q;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (flush_i && count_q != '0) state_d = ROLLBACK;
      ROLLBACK: if (count_q == CNT_W'(1))     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      free_valid_o <= 1'b0;
      free_prd_o   <= '0;
      rb_valid_o   <= 1'b0;
      rb_rd_o      <= '0;
      rb_prd_o     <= '0;
      err_o        <= 1'b0;
    end else begin
      free_valid_o <= 1'b0;
      rb_valid_o   <= 1'b0;
      if (do_rb) begin
        tail_q       <= rb_idx;
        count_q      <= count_q - CNT_W'(1);
        rb_valid_o   <= 1'b1;
        rb_rd_o      <= rd_mem[rb_idx];
        rb_prd_o     <= old_prd_mem[rb_idx];
        free_valid_o <= (prd_mem[rb_idx] != '0);
        free_prd_o   <= prd_mem[rb_idx];
      end else begin
        if (do_alloc) tail_q <= tail_q + PTR_W'(1);
        if (do_commit) begin
          head_q       <= head_q + PTR_W'(1);
          free_valid_o <= (old_prd_mem[head_q] != '0);
          free_prd_o   <= old_prd_mem[head_q];
          if (commit_prd_i != prd_mem[head_q]) err_o <= 1'b1;
        end
        case ({do_alloc, do_commit})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: entry storage is not reset; head/tail/count alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      rd_mem[tail_q]      <= alloc_rd_i;
      prd_mem[tail_q]     <= alloc_prd_i;
      old_prd_mem[tail_q] <= alloc_old_prd_i;
    end
  end

endmodule

// File: tb/tb_rename_commit_tracker.sv
// Directed self-checking bench for rename_commit_tracker with hand-computed expectations.
module tb_rename_commit_tracker;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       alloc_valid_i, alloc_ready_o;
  logic [4:0] alloc_rd_i;
  logic [5:0] alloc_prd_i, alloc_old_prd_i;
  logic       commit_valid_i, commit_ready_o;
  logic [5:0] commit_prd_i;
  logic       flush_i;
  logic       free_valid_o;
  logic [5:0] free_prd_o;
  logic       rb_valid_o;
  logic [4:0] rb_rd_o;
  logic [5:0] rb_prd_o;
  logic [3:0] count_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  rename_commit_tracker #(.ARCH_REG_WIDTH(5), .PHYS_REG_WIDTH(6), .DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rd_i(alloc_rd_i), .alloc_prd_i(alloc_prd_i), .alloc_old_prd_i(alloc_old_prd_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .commit_prd_i(commit_prd_i), .flush_i(flush_i),
    .free_valid_o(free_valid_o), .free_prd_o(free_prd_o),
    .rb_valid_o(rb_valid_o), .rb_rd_o(rb_rd_o), .rb_prd_o(rb_prd_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [5:0] prd, input logic [5:0] old);
    alloc_valid_i = 1'b1; alloc_rd_i = rd; alloc_prd_i = prd; alloc_old_prd_i = old;
    step();
    alloc_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [5:0] prd);
    commit_valid_i = 1'b1; commit_prd_i = prd;
    step();
    commit_valid_i = 1'b0;
  endtask

  task automatic check_rb(input string tag, input logic [4:0] rd, input logic [5:0] rprd,
                          input logic fv, input logic [5:0] fprd);
    check({tag, "_rb_valid"}, 32'(rb_valid_o), 32'd1);
    check({tag, "_rb_rd"}, 32'(rb_rd_o), 32'(rd));
    check({tag, "_rb_prd"}, 32'(rb_prd_o), 32'(rprd));
    check({tag, "_free_valid"}, 32'(free_valid_o), 32'(fv));
    check({tag, "_free_prd"}, 32'(free_prd_o), 32'(fprd));
  endtask

  initial begin
    rst_i = 1'b1;
    alloc_valid_i = 1'b0; alloc_rd_i = '0; alloc_prd_i = '0; alloc_old_prd_i = '0;
    commit_valid_i = 1'b0; commit_prd_i = '0; flush_i = 1'b0;
    #12;
    check("rst_alloc_ready", 32'(alloc_ready_o), 32'd1);
    check("rst_commit_ready", 32'(commit_ready_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_free_valid", 32'(free_valid_o), 32'd0);
    check("rst_rb_valid", 32'(rb_valid_o), 32'd0);
    rst_i = 1'b0;
    step();

    // Commit of an entry whose old mapping is p0: nothing freed.
    alloc(5'd4, 6'd1, 6'd0);
    check("s1_count_1", 32'(count_o), 32'd1);
    check("s1_commit_ready", 32'(commit_ready_o), 32'd1);
    commit(6'd1);
    check("s1_free_valid", 32'(free_valid_o), 32'd0);
    check("s1_count_0", 32'(count_o), 32'd0);
    check("s1_err", 32'(err_o), 32'd0);

    // Remap of r3: second commit frees p3.
    alloc(5'd3, 6'd3, 6'd0);
    alloc(5'd3, 6'd4, 6'd3);
    commit(6'd3);
    check("s2_free_valid_a", 32'(free_valid_o), 32'd0);
    commit(6'd4);
    check("s2_free_valid_b", 32'(free_valid_o), 32'd1);
    check("s2_free_prd", 32'(free_prd_o), 32'd3);
    step();
    check("s2_free_pulse", 32'(free_valid_o), 32'd0);
    check("s2_count", 32'(count_o), 32'd0);

    // Full FIFO: commit frees a slot but does not raise ready in that cycle.
    for (int i = 0; i < 8; i++) alloc(5'(i), 6'(10 + i), 6'(20 + i));
    check("s3_count_full", 32'(count_o), 32'd8);
    alloc_valid_i = 1'b1; alloc_rd_i = 5'd1; alloc_prd_i = 6'd30; alloc_old_prd_i = 6'd31;
    commit_valid_i = 1'b1; commit_prd_i = 6'd10;
    check("s3_alloc_ready_full", 32'(alloc_ready_o), 32'd0);
    step();
    commit_valid_i = 1'b0;
    check("s3_count_7", 32'(count_o), 32'd7);
    check("s3_free_prd", 32'(free_prd_o), 32'd20);
    check("s3_alloc_ready_7", 32'(alloc_ready_o), 32'd1);
    step();
    alloc_valid_i = 1'b0;
    check("s3_count_refill", 32'(count_o), 32'd8);
    for (int i = 1; i < 8; i++) begin
      commit(6'(10 + i));
      check($sformatf("s3_drain_free_%0d", i), 32'(free_prd_o), 32'(20 + i));
    end
    commit(6'd30);
    check("s3_drain_last_free", 32'(free_prd_o), 32'd31);
    check("s3_drain_count", 32'(count_o), 32'd0);
    check("s3_drain_err", 32'(err_o), 32'd0);

    // Flush with nothing in flight is a no-op.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("s4_empty_flush_rb", 32'(rb_valid_o), 32'd0);
    check("s4_empty_flush_ready", 32'(alloc_ready_o), 32'd1);

    // Rollback replays youngest first.
    alloc(5'd4, 6'd1, 6'd0);
    alloc(5'd5, 6'd2, 6'd0);
    alloc(5'd3, 6'd3, 6'd7);
    flush_i = 1'b1; alloc_valid_i = 1'b1; alloc_rd_i = 5'd9; alloc_prd_i = 6'd9;
    step();
    flush_i = 1'b0; alloc_valid_i = 1'b0;
    check("s5_flush_count", 32'(count_o), 32'd3);
    check("s5_flush_ready", 32'(alloc_ready_o), 32'd0);
    check("s5_flush_rb_idle", 32'(rb_valid_o), 32'd0);
    step();
    check_rb("s5_p1", 5'd3, 6'd7, 1'b1, 6'd3);
    check("s5_p1_ready", 32'(alloc_ready_o), 32'd0);
    step();
    check_rb("s5_p2", 5'd5, 6'd0, 1'b1, 6'd2);
    check("s5_p2_ready", 32'(alloc_ready_o), 32'd0);
    step();
    check_rb("s5_p3", 5'd4, 6'd0, 1'b1, 6'd1);
    check("s5_end_count", 32'(count_o), 32'd0);
    check("s5_end_ready", 32'(alloc_ready_o), 32'd1);
    step();
    check("s5_rb_done", 32'(rb_valid_o), 32'd0);

    // Mismatched commit sets a sticky error; pop and free still happen.
    alloc(5'd4, 6'd1, 6'd0);
    alloc(5'd6, 6'd5, 6'd2);
    commit(6'd9);
    check("s6_err_set", 32'(err_o), 32'd1);
    check("s6_err_count", 32'(count_o), 32'd1);
    commit(6'd5);
    check("s6_err_sticky", 32'(err_o), 32'd1);
    check("s6_free_prd", 32'(free_prd_o), 32'd2);

    // Asynchronous reset in the middle of a rollback.
    alloc(5'd1, 6'd11, 6'd21);
    alloc(5'd2, 6'd12, 6'd22);
    alloc(5'd3, 6'd13, 6'd23);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    check_rb("s7_p1", 5'd3, 6'd23, 1'b1, 6'd13);
    #2 rst_i = 1'b1;
    #1;
    check("s7_rst_rb", 32'(rb_valid_o), 32'd0);
    check("s7_rst_free", 32'(free_valid_o), 32'd0);
    check("s7_rst_rb_rd", 32'(rb_rd_o), 32'd0);
    check("s7_rst_count", 32'(count_o), 32'd0);
    check("s7_rst_ready", 32'(alloc_ready_o), 32'd1);
    check("s7_rst_err", 32'(err_o), 32'd0);
    step();
    rst_i = 1'b0;
    step();
    check("s7_post_rb", 32'(rb_valid_o), 32'd0);
    step();
    check("s7_post_rb2", 32'(rb_valid_o), 32'd0);
    check("s7_post_count", 32'(count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
